rsa_host_ctrl: RTL and testbench
================================

// Module: rsa_host_ctrl
// PURPOSE
//  Host-side initiator for the byte-wide register port of the RSA exponentiation core.
//  Takes three 256-bit operands (msg, exp, mod) in one request and writes them into the core byte by byte.
//  Then pulses the core start, waits for completion, reads back the 32 result bytes and returns a 256-bit result.
//  Sits between the top-level host logic (UART/switch front end) and the RSA core.
// PARAMETERS
//  NBYTES    32       bytes per operand; operand width = 8*NBYTES
//  MIN_WAIT  2        cycles after start before core_ready is sampled
//  TIMEOUT   1048576  max WAIT cycles before abort; 20-bit counter
// PORTS
//  clk          in   1    system clock, all state on posedge
//  reset        in   1    asynchronous, active-low reset
//  req          in   1    start a transaction; sampled only in IDLE
//  msg          in   256  base operand, written to reg_sel 1; sampled at accept
//  exp          in   256  exponent, written to reg_sel 2; sampled at accept
//  mod          in   256  modulus, written to reg_sel 3; sampled at accept
//  busy         out  1    high from accept until DONE cycle inclusive
//  done         out  1    one-cycle pulse; result is valid
//  timeout      out  1    one-cycle pulse alongside done when WAIT expired
//  result       out  256  assembled result; held until next accept
//  core_we      out  1    active-low write strobe to core
//  core_oe      out  1    active-low read strobe to core
//  core_start   out  1    active-low start to core
//  core_reg_sel out  2    register select: 0=result, 1=msg, 2=exp, 3=mod
//  core_addr    out  5    byte index, 0 = bits [7:0]
//  core_wdata   out  8    write byte to core data_i
//  core_rdata   in   8    core data_o; registered by core, valid 1 cycle after addr
//  core_ready   in   1    core status; low = idle/finished
// BEHAVIOUR
//  Reset (async, reset==0):
//   - State goes to IDLE. busy=0, done=0, timeout=0, result=0.
//   - core_we=1, core_oe=1, core_start=1, core_reg_sel=0, core_addr=0, core_wdata=0.
//   - Reset mid-transaction aborts immediately with no done pulse. The core keeps whatever it already holds.
//  All outputs are registered.
//  FSM: IDLE -> LOAD -> START -> WAIT -> READ -> DONE -> IDLE.
//  IDLE:
//   - On req=1, latch msg/exp/mod into shadow registers and set busy=1 next cycle.
//   - req is ignored in every other state; it is not queued.
//  LOAD (96 cycles):
//   - Write order: reg_sel 3, then 1, then 2. Within each, addr 0..31.
//   - One byte per cycle with core_we=0 and core_wdata = operand[8*addr+7 : 8*addr].
//   - core_oe=1 throughout.
//   - core_we returns to 1 on the cycle after the last byte (sel 2, addr 31).
//  START (1 cycle):
//   - core_start=0, then back to 1. Strobes are idle, reg_sel=0.
//  WAIT:
//   - A 20-bit counter clears on entry.
//   - For the first MIN_WAIT cycles core_ready is ignored.
//   - After that, core_ready=0 moves to READ.
//   - If the counter reaches TIMEOUT-1 first, set a sticky abort flag and move to READ anyway.
//  READ (33 cycles):
//   - core_reg_sel=0, core_oe=0, core_addr=0..31 on cycles 0..31.
//   - On cycles 1..32, capture core_rdata into result[8*(k-1)+7 : 8*(k-1)].
//   - core_oe=1 on cycle 32.
//  DONE (1 cycle):
//   - done=1. timeout=abort flag. busy=1 this cycle, 0 next.
//   - Abort flag clears on IDLE entry.
//  Latency, req accepted to done, with no timeout:
//   - 96 + 1 + W + 33 + 1 cycles, where W is the WAIT length (>= MIN_WAIT+1).
//  Strobe and counter rules:
//   - core_we and core_oe are never low in the same cycle.
//   - Byte counter wraps 31->0 with a reg_sel advance; there is no other wrap.
// TESTING
//  1. Reset with req=1 held: no core_we/oe/start low and busy=0 until reset release; then accept on the first edge.
//  2. mod=2^255+1, msg=0x0102..20 (byte k=k+1), exp=3:
//     - 96 writes in order sel3/1/2, addr 0..31, with exact bytes checked.
//     - Exactly one core_start=0 pulse.
//  3. Core model drops ready 10 cycles after start and returns byte k=0xA0+k:
//     - result byte k = 0xA0+k, timeout=0.
//     - Total latency 96+1+10+33+1 = 141 cycles.
//  4. TIMEOUT=64, core_ready stuck 1: READ starts at WAIT cycle 63; done and timeout pulse together.
//  5. req held high across a whole transaction plus back-to-back req: second accept only after DONE.
//     Operand change during LOAD does not affect written bytes.
//  6. Reset asserted at LOAD byte 40 and during READ byte 5:
//     - Outputs return to reset values asynchronously.
//     - No done pulse; a new req completes normally.

Source files
------------

// File: rtl/rsa_host_ctrl_if.sv
// Byte-wide register port between the host controller and the RSA core.
// All strobes are active-low; rdata is registered by the core one cycle after addr.
interface rsa_host_ctrl_if #(
   parameter int NBYTES = 32
);
   localparam int AW = $clog2(NBYTES);

   logic          we;
   logic          oe;
   logic          start;
   logic [1:0]    reg_sel;
   logic [AW-1:0] addr;
   logic [7:0]    wdata;
   logic [7:0]    rdata;
   logic          ready;

   modport master (
      output we, oe, start, reg_sel, addr, wdata,
      input  rdata, ready
   );

   modport slave (
      input  we, oe, start, reg_sel, addr, wdata,
      output rdata, ready
   );
endinterface

// File: rtl/rsa_host_ctrl.sv
// Host-side initiator for the RSA core: loads mod/msg/exp byte by byte, starts the core,
// waits for completion (with timeout) and reads back the result bytes.
//
//   state   | meaning
//   S_IDLE  | waiting for req; operands latched on accept
//   S_LOAD  | one operand byte written per cycle, order sel 3, 1, 2
//   S_START | single-cycle active-low start pulse
//   S_WAIT  | wait for core_ready low after MIN_WAIT cycles, or timeout
//   S_READ  | addr 0..NBYTES-1 driven, bytes captured one cycle later
//   S_DONE  | done pulse, timeout flags an expired wait
module rsa_host_ctrl #(
   parameter int NBYTES   = 32,
   parameter int MIN_WAIT = 2,
   parameter int TIMEOUT  = 1048576
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [8*NBYTES-1:0]   msg,
   input  logic [8*NBYTES-1:0]   exp,
   input  logic [8*NBYTES-1:0]   mod,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [8*NBYTES-1:0]   result,
   rsa_host_ctrl_if.master       core
);
   localparam int OPW = 8*NBYTES;
   localparam int AW  = $clog2(NBYTES);
   localparam logic [AW-1:0] LAST_BYTE = AW'(NBYTES-1);
   localparam logic [AW:0]   RD_LAST   = (AW+1)'(NBYTES);
   localparam logic [AW:0]   RD_OE_OFF = (AW+1)'(NBYTES-1);
   localparam logic [19:0]   WAIT_LAST = 20'(TIMEOUT-1);
   localparam logic [19:0]   WAIT_MIN  = 20'(MIN_WAIT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_DONE
   } state_t;

   state_t          state;
   logic [OPW-1:0]  msg_q, exp_q, mod_q;
   logic [19:0]     wcnt;
   logic [AW:0]     rcnt;
   logic            abort;

   logic [1:0]      next_sel;
   logic [AW-1:0]   next_addr;
   logic [OPW-1:0]  next_op;
   logic [7:0]      next_byte;
   logic [AW-1:0]   cap_idx;

   // Next LOAD byte: addr wraps to 0 only together with a reg_sel advance (3 -> 1 -> 2).
   always_comb begin
      next_sel  = core.reg_sel;
      next_addr = core.addr + AW'(1);
      if (core.addr == LAST_BYTE) begin
         next_addr = '0;
         next_sel  = (core.reg_sel == 2'd3) ? 2'd1 : 2'd2;
      end
      case (next_sel)
         2'd1:    next_op = msg_q;
         2'd2:    next_op = exp_q;
         default: next_op = mod_q;
      endcase
      next_byte = next_op[{next_addr, 3'b000} +: 8];
      cap_idx   = rcnt[AW-1:0] - AW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         result       <= '0;
         core.we      <= 1'b1;
         core.oe      <= 1'b1;
         core.start   <= 1'b1;
         core.reg_sel <= 2'd0;
         core.addr    <= '0;
         core.wdata   <= 8'h00;
         msg_q        <= '0;
         exp_q        <= '0;
         mod_q        <= '0;
         wcnt         <= '0;
         rcnt         <= '0;
         abort        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done    <= 1'b0;
               timeout <= 1'b0;
               if (req) begin
                  msg_q        <= msg;
                  exp_q        <= exp;
                  mod_q        <= mod;
                  busy         <= 1'b1;
                  abort        <= 1'b0;
                  core.we      <= 1'b0;
                  core.reg_sel <= 2'd3;
                  core.addr    <= '0;
                  core.wdata   <= mod[7:0];
                  state        <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (core.addr == LAST_BYTE && core.reg_sel == 2'd2) begin
                  core.we      <= 1'b1;
                  core.start   <= 1'b0;
                  core.reg_sel <= 2'd0;
                  core.addr    <= '0;
                  core.wdata   <= 8'h00;
                  state        <= S_START;
               end else begin
                  core.reg_sel <= next_sel;
                  core.addr    <= next_addr;
                  core.wdata   <= next_byte;
               end
            end
            S_START: begin
               core.start <= 1'b1;
               wcnt       <= '0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               wcnt <= wcnt + 20'd1;
               // A finished core wins over a timeout expiring in the same cycle.
               if ((wcnt >= WAIT_MIN && !core.ready) || wcnt == WAIT_LAST) begin
                  if (!(wcnt >= WAIT_MIN && !core.ready))
                     abort <= 1'b1;
                  core.oe   <= 1'b0;
                  core.addr <= '0;
                  rcnt      <= '0;
                  state     <= S_READ;
               end
            end
            S_READ: begin
               rcnt <= rcnt + (AW+1)'(1);
               if (rcnt != '0)
                  result[{cap_idx, 3'b000} +: 8] <= core.rdata;
               if (rcnt < RD_OE_OFF)
                  core.addr <= core.addr + AW'(1);
               if (rcnt == RD_OE_OFF)
                  core.oe <= 1'b1;
               if (rcnt == RD_LAST) begin
                  done    <= 1'b1;
                  timeout <= abort;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               timeout <= 1'b0;
               busy    <= 1'b0;
               abort   <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Directed bench for rsa_host_ctrl with a small behavioural RSA core on the register port.
`timescale 1ns/1ps

module tb_rsa_host_ctrl;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req = 1'b0;
   logic [255:0] msg_v = '0;
   logic [255:0] exp_v = '0;
   logic [255:0] mod_v = '0;
   logic         busy, done, timeout;
   logic [255:0] result;

   rsa_host_ctrl_if #(.NBYTES(32)) core_bus ();

   rsa_host_ctrl #(.NBYTES(32), .MIN_WAIT(2), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .req(req),
      .msg(msg_v), .exp(exp_v), .mod(mod_v),
      .busy(busy), .done(done), .timeout(timeout), .result(result),
      .core(core_bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Core model: ready rises when start is seen, falls ready_delay edges later unless stuck.
   logic       rdy_q = 1'b0;
   logic [7:0] rdata_q = 8'h00;
   int         rc = 0;
   int         ready_delay = 9;
   logic       stuck = 1'b0;
   logic [7:0] rd_base = 8'hA0;

   assign core_bus.ready = rdy_q;
   assign core_bus.rdata = rdata_q;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_bus.oe === 1'b0)
         rdata_q <= rd_base + 8'(core_bus.addr);
      if (core_bus.start === 1'b0) begin
         rdy_q <= 1'b1;
         rc    <= ready_delay;
      end else if (rdy_q && !stuck) begin
         if (rc <= 1) rdy_q <= 1'b0;
         else rc <= rc - 1;
      end
   end

   logic [14:0] wr_log [1024];
   int   wr_cnt = 0, start_cnt = 0, oe_cnt = 0, ovl = 0, done_cnt = 0, rd_first = 0;
   logic oe_prev = 1'b1;

   always @(negedge clk) begin
      if (core_bus.we === 1'b0) begin
         if (wr_cnt < 1024) wr_log[wr_cnt] <= {core_bus.reg_sel, core_bus.addr, core_bus.wdata};
         wr_cnt <= wr_cnt + 1;
      end
      if (core_bus.start === 1'b0) start_cnt <= start_cnt + 1;
      if (core_bus.oe === 1'b0) begin
         oe_cnt <= oe_cnt + 1;
         if (oe_prev) rd_first <= cyc;
      end
      oe_prev <= core_bus.oe;
      if (core_bus.we === 1'b0 && core_bus.oe === 1'b0) ovl <= ovl + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, output int seen_at);
      seen_at = -1;
      for (int i = 0; i < budget && seen_at < 0; i++) begin
         tick();
         if (done === 1'b1) seen_at = cyc;
      end
   endtask

   function automatic logic [255:0] ramp(input logic [7:0] base);
      logic [255:0] r;
      for (int k = 0; k < 32; k++) r[8*k +: 8] = base + 8'(k);
      return r;
   endfunction

   function automatic logic [14:0] t2_exp(input int i);
      logic [1:0] s;
      logic [4:0] a;
      logic [7:0] d;
      a = 5'(i % 32);
      if (i < 32) begin
         s = 2'd3;
         d = (a == 5'd0) ? 8'h01 : (a == 5'd31) ? 8'h80 : 8'h00;
      end else if (i < 64) begin
         s = 2'd1;
         d = 8'(a) + 8'h01;
      end else begin
         s = 2'd2;
         d = (a == 5'd0) ? 8'h03 : 8'h00;
      end
      return {s, a, d};
   endfunction

   int e0, seen, base, dc0, found;

   initial begin
      // Reset held with req=1 and the ramp operands presented
      mod_v = {1'b1, 254'b0, 1'b1};
      exp_v = 256'd3;
      for (int k = 0; k < 32; k++) msg_v[8*k +: 8] = 8'(k + 1);
      req = 1'b1;
      repeat (3) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_result", result, 256'd0);
      chk("rst_we", core_bus.we, 1'b1);
      chk("rst_oe", core_bus.oe, 1'b1);
      chk("rst_start", core_bus.start, 1'b1);
      chk("rst_sel", core_bus.reg_sel, 2'd0);
      chk("rst_addr", core_bus.addr, 5'd0);
      chk("rst_wdata", core_bus.wdata, 8'h00);
      chk("rst_no_strobes", wr_cnt + start_cnt + oe_cnt, 0);

      reset = 1'b1;
      e0 = cyc;
      tick();
      chk("acc_busy", busy, 1'b1);
      chk("acc_we", core_bus.we, 1'b0);
      chk("acc_sel", core_bus.reg_sel, 2'd3);
      chk("acc_addr", core_bus.addr, 5'd0);
      chk("acc_wdata", core_bus.wdata, 8'h01);
      req = 1'b0;

      wait_done(400, seen);
      chk("t3_latency", seen - e0, 141);
      chk("t3_timeout", timeout, 1'b0);
      chk("t3_result", result, ramp(8'hA0));
      chk("t3_busy_in_done", busy, 1'b1);
      chk("t3_read_start", rd_first - e0, 108);
      tick();
      chk("t3_busy_after", busy, 1'b0);
      chk("t3_done_pulse", done, 1'b0);

      chk("t2_write_count", wr_cnt, 96);
      chk("t2_start_pulses", start_cnt, 1);
      for (int i = 0; i < 96; i++) chk("t2_write", wr_log[i], t2_exp(i));

      // Timeout: ready never drops
      repeat (5) tick();
      stuck = 1'b1;
      rd_base = 8'h40;
      req = 1'b1;
      e0 = cyc;
      tick();
      req = 1'b0;
      wait_done(400, seen);
      chk("t4_latency", seen - e0, 195);
      chk("t4_timeout", timeout, 1'b1);
      chk("t4_result", result, ramp(8'h40));
      chk("t4_read_start", rd_first - e0, 162);
      tick();
      chk("t4_timeout_pulse", timeout, 1'b0);
      chk("t4_done_pulse", done, 1'b0);
      stuck = 1'b0;
      repeat (12) tick();

      // req held high through a transaction, operands changed mid-LOAD
      msg_v = {32{8'h5A}};
      exp_v = {32{8'hC3}};
      mod_v = {32{8'h3C}};
      rd_base = 8'hA0;
      base = wr_cnt;
      dc0 = done_cnt;
      req = 1'b1;
      tick();
      chk("t5_accept", busy, 1'b1);
      repeat (5) tick();
      msg_v = {32{8'hFF}};
      exp_v = {32{8'hFF}};
      mod_v = {32{8'hFF}};
      wait_done(400, seen);
      chk("t5_done_seen", seen > 0, 1'b1);
      chk("t5_write_count", wr_cnt - base, 96);
      chk("t5_byte_mod5", wr_log[base + 5], {2'd3, 5'd5, 8'h3C});
      chk("t5_byte_msg8", wr_log[base + 40], {2'd1, 5'd8, 8'h5A});
      chk("t5_byte_exp31", wr_log[base + 95], {2'd2, 5'd31, 8'hC3});
      chk("t5_busy_in_done", busy, 1'b1);
      tick();
      chk("t5_idle_gap", busy, 1'b0);
      tick();
      chk("t5_reaccept", busy, 1'b1);
      chk("t5_second_byte0", wr_log[base + 96], {2'd3, 5'd0, 8'hFF});
      req = 1'b0;
      wait_done(400, seen);
      chk("t5_second_result", result, ramp(8'hA0));
      chk("t5_done_count", done_cnt - dc0, 2);
      repeat (3) tick();

      // Reset during LOAD byte 40
      mod_v = {1'b1, 254'b0, 1'b1};
      exp_v = 256'd3;
      for (int k = 0; k < 32; k++) msg_v[8*k +: 8] = 8'(k + 1);
      dc0 = done_cnt;
      req = 1'b1;
      tick();
      req = 1'b0;
      repeat (40) tick();
      chk("t6_load40_sel", core_bus.reg_sel, 2'd1);
      chk("t6_load40_addr", core_bus.addr, 5'd8);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t6_load_rst_we", core_bus.we, 1'b1);
      chk("t6_load_rst_busy", busy, 1'b0);
      chk("t6_load_rst_sel", core_bus.reg_sel, 2'd0);
      chk("t6_load_rst_addr", core_bus.addr, 5'd0);
      chk("t6_load_rst_wdata", core_bus.wdata, 8'h00);
      repeat (2) tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("t6_load_no_done", done_cnt, dc0);
      chk("t6_load_idle", busy, 1'b0);

      // Reset during READ byte 5
      req = 1'b1;
      tick();
      req = 1'b0;
      found = 0;
      for (int i = 0; i < 300 && found == 0; i++) begin
         tick();
         if (core_bus.oe === 1'b0) found = 1;
      end
      chk("t6_read_reached", found, 1);
      repeat (5) tick();
      chk("t6_read5_addr", core_bus.addr, 5'd5);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t6_read_rst_oe", core_bus.oe, 1'b1);
      chk("t6_read_rst_busy", busy, 1'b0);
      chk("t6_read_rst_result", result, 256'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("t6_read_no_done", done_cnt, dc0);

      // Fresh transaction after the aborts
      rd_base = 8'h17;
      req = 1'b1;
      e0 = cyc;
      tick();
      req = 1'b0;
      wait_done(400, seen);
      chk("t6_new_latency", seen - e0, 141);
      chk("t6_new_result", result, ramp(8'h17));
      chk("t6_new_timeout", timeout, 1'b0);
      tick();
      chk("t6_new_done_count", done_cnt, dc0 + 1);
      chk("we_oe_overlap", ovl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
